// File: rtl/tt_pin_arb_pkg.sv
// Shared types and width helpers for the pin arbiter.
package tt_pin_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Width of an owner / pointer index; never narrower than one bit.
    function automatic int owner_w(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

    // Width of the saturating hold counter; a disabled timeout still keeps one bit.
    function automatic int hold_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

    // Width of the turnaround counter, which counts 0..TURN_CYC-1.
    function automatic int turn_w(input int turn_cyc);
        return (turn_cyc > 1) ? $clog2(turn_cyc) : 1;
    endfunction

    // Default configuration and the widths derived from it.
    localparam int DEF_N_REQ    = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_TURN_CYC = 1;
    localparam int OWNER_W      = owner_w(DEF_N_REQ);
    localparam int HOLD_W       = hold_w(DEF_MAX_HOLD);

endpackage

// File: rtl/tt_pin_arb_chk.sv
// Invariant checker for the pin arbiter outputs.
module tt_pin_arb_chk #(
    parameter int N_REQ = 4,
    parameter int W     = 8
)(
    input logic             clk,
    input logic             rst,
    input logic [N_REQ-1:0] gnt,
    input logic [W-1:0]     pin_oe,
    input logic             busy
);

    // At most one requester owns the pins.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    // A live grant always reports the arbiter as busy.
    a_gnt_busy: assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> busy);

    // Enables are only ever driven while somebody holds the grant.
    a_oe_owned: assert property (@(posedge clk) disable iff (rst) (pin_oe != '0) |-> (gnt != '0));

endmodule

// File: rtl/tt_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module tt_rr_picker
    import tt_pin_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int OW    = owner_w(DEF_N_REQ)
)(
    input  logic [N_REQ-1:0] req_i,
    input  logic [OW-1:0]    ptr_i,
    output logic [OW-1:0]    win_o,
    output logic             vld_o
);

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        logic [OW:0]   sum;
        logic [OW-1:0] idx;
        win_o = '0;
        vld_o = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr_i} + (OW+1)'(k);
            if (sum >= (OW+1)'(N_REQ)) begin
                sum = sum - (OW+1)'(N_REQ);
            end else begin
                sum = sum;
            end
            idx = sum[OW-1:0];
            if (!vld_o && req_i[idx]) begin
                win_o = idx;
                vld_o = 1'b1;
            end else begin
                win_o = win_o;
            end
        end
    end

endmodule

// File: rtl/tt_pin_arbiter.sv
// Round-robin owner of the shared output / bidirectional pins, with bounded
// hold time and an all-enables-low turnaround gap between owners.
module tt_pin_arbiter
    import tt_pin_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN_CYC = DEF_TURN_CYC
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*W-1:0]        wdata,
    input  logic [N_REQ*W-1:0]        woe,
    output logic [N_REQ-1:0]          gnt,
    output logic [W-1:0]              pin_out,
    output logic [W-1:0]              pin_oe,
    output logic [owner_w(N_REQ)-1:0] owner,
    output logic                      busy,
    output logic                      timeout
);

    localparam int OW = owner_w(N_REQ);
    localparam int HW = hold_w(MAX_HOLD);
    localparam int TW = turn_w(TURN_CYC);

    // Timeout fires when the counter reaches MAX_HOLD-1, i.e. on the last allowed cycle.
    localparam logic          TO_EN     = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
    localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);
    localparam logic [OW-1:0] OWN_TOP   = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_e       state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [W-1:0]     pin_out_q;
    logic [W-1:0]     pin_oe_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    ptr_q;
    logic [HW-1:0]    hold_q;
    logic [TW-1:0]    turn_q;
    logic             busy_q;
    logic             timeout_q;

    logic [OW-1:0]    pick_win_d;
    logic             pick_vld_d;
    logic [W-1:0]     own_wdata_d;
    logic [W-1:0]     own_woe_d;
    logic             rel_last_d;
    logic             rel_drop_d;
    logic             rel_hold_d;
    logic             rel_d;
    logic             to_only_d;
    logic [OW-1:0]    ptr_nxt_d;
    logic [HW-1:0]    hold_inc_d;

    tt_rr_picker #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win_d),
        .vld_o (pick_vld_d)
    );

    // Select the owner's data slice and decode the release conditions.
    always_comb begin
        own_wdata_d = '0;
        own_woe_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_wdata_d = wdata[i*W +: W];
                own_woe_d   = woe[i*W +: W];
            end else begin
                own_wdata_d = own_wdata_d;
                own_woe_d   = own_woe_d;
            end
        end
        rel_last_d = last[owner_q];
        rel_drop_d = ~req[owner_q];
        rel_hold_d = TO_EN && (hold_q == HOLD_LAST);
        rel_d      = rel_last_d | rel_drop_d | rel_hold_d;
        // A timeout is only reported when the hold limit is the sole reason.
        to_only_d  = rel_hold_d & ~rel_last_d & ~rel_drop_d;
        if (owner_q == OWN_TOP) begin
            ptr_nxt_d = '0;
        end else begin
            ptr_nxt_d = owner_q + OW'(1);
        end
        if (hold_q == HOLD_SAT) begin
            hold_inc_d = hold_q;
        end else begin
            hold_inc_d = hold_q + HW'(1);
        end
    end

    // Arbiter FSM with registered grant, pin mux, pointer and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            pin_out_q <= '0;
            pin_oe_q  <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pin_out_q <= '0;
                    pin_oe_q  <= '0;
                    if (pick_vld_d) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= GNT_ONE << pick_win_d;
                        owner_q <= pick_win_d;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (rel_d) begin
                        gnt_q     <= '0;
                        pin_out_q <= '0;
                        pin_oe_q  <= '0;
                        ptr_q     <= ptr_nxt_d;
                        timeout_q <= to_only_d;
                        turn_q    <= '0;
                        if (TURN_CYC == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_TURN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        pin_out_q <= own_wdata_d;
                        pin_oe_q  <= own_woe_d;
                        hold_q    <= hold_inc_d;
                    end
                end
                ST_TURN: begin
                    gnt_q     <= '0;
                    pin_out_q <= '0;
                    pin_oe_q  <= '0;
                    if (turn_q == TURN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        turn_q <= turn_q + TW'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    gnt_q     <= '0;
                    pin_out_q <= '0;
                    pin_oe_q  <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign pin_out = pin_out_q;
    assign pin_oe  = pin_oe_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

    tt_pin_arb_chk #(
        .N_REQ (N_REQ),
        .W     (W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .gnt    (gnt_q),
        .pin_oe (pin_oe_q),
        .busy   (busy_q)
    );

endmodule

// File: tb/tb_tt_pin_arbiter.sv
// Scoreboard bench for tt_pin_arbiter: a default build (TURN_CYC=1) and a
// TURN_CYC=0 build share clock and reset.
module tb_tt_pin_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, last, gnt;
    logic [31:0] wdata, woe;
    logic [7:0]  pin_out, pin_oe;
    logic [1:0]  owner;
    logic        busy, timeout;

    logic [3:0]  req_z, last_z, gnt_z;
    logic [7:0]  pin_out_z, pin_oe_z;
    logic [1:0]  owner_z;
    logic        busy_z, timeout_z;

    logic [7:0] dat_tab [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
    logic [7:0] oe_tab  [4] = '{8'hFF, 8'h0F, 8'hFF, 8'hF0};

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    // Pins idle between two owners: release+1 .. next first grant cycle -> TURN_CYC+2.
    // Grant idle between owners: TURN cycles plus the arbitrating IDLE cycle -> TURN_CYC+1.
    localparam int OE_GAP1 = 3;
    localparam int G_GAP1  = 2;
    localparam int OE_GAP0 = 2;
    localparam int G_GAP0  = 1;

    always #5 clk = ~clk;

    tt_pin_arbiter #(.N_REQ(4), .W(8), .MAX_HOLD(16), .TURN_CYC(1)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .wdata(wdata), .woe(woe),
        .gnt(gnt), .pin_out(pin_out), .pin_oe(pin_oe), .owner(owner),
        .busy(busy), .timeout(timeout)
    );

    tt_pin_arbiter #(.N_REQ(4), .W(8), .MAX_HOLD(16), .TURN_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req_z), .last(last_z), .wdata(wdata), .woe(woe),
        .gnt(gnt_z), .pin_out(pin_out_z), .pin_oe(pin_oe_z), .owner(owner_z),
        .busy(busy_z), .timeout(timeout_z)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (gnt == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        if (gnt == 4'b0000) begin
            total++;
            bad++;
            $display("FAIL wait_gnt: no grant within %0d cycles", n);
        end
    endtask

    // Hold the grant until its k-th cycle, then raise last (and optionally drop req).
    task automatic serve(input int k, input bit drop);
        wait_gnt();
        for (int j = 1; j < k; j++) tick();
        last = gnt;
        if (drop) req = 4'b0000;
        tick();
        last = 4'b0000;
    endtask

    // Scoreboard monitor: each new grant pops the expected owner; pins checked one cycle later.
    logic [3:0] mon_prev = 4'b0000;
    int         mon_cur  = 0;
    bit         mon_pend = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                mon_pend = 1'b0;
                chk("sb_pin_out", 32'(pin_out), 32'(dat_tab[mon_cur]));
                chk("sb_pin_oe", 32'(pin_oe), 32'(oe_tab[mon_cur]));
            end
            if (gnt != 4'b0000 && gnt != mon_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_grant: unexpected gnt %b", gnt);
                end else begin
                    mon_cur = exp_q.pop_front();
                    chk("sb_gnt", 32'(gnt), 32'(1) << mon_cur);
                    chk("sb_owner", 32'(owner), 32'(mon_cur));
                    mon_pend = 1'b1;
                end
            end
            mon_prev = gnt;
        end
    end

    // Gap monitors: length of the idle runs of pin_oe and gnt between owners.
    bit gap_en = 1'b0, gap_en_z = 1'b0;
    bit oe_seen, g_seen, oe_seen_z, g_seen_z;
    int oe_run, g_run, oe_run_z, g_run_z;
    initial begin
        forever begin
            @(negedge clk);
            if (!gap_en) begin
                oe_seen = 1'b0; g_seen = 1'b0; oe_run = 0; g_run = 0;
            end else begin
                if (pin_oe != 8'h00) begin
                    if (oe_seen && oe_run > 0) chk("oe_gap", 32'(oe_run), 32'(OE_GAP1));
                    oe_seen = 1'b1; oe_run = 0;
                end else oe_run++;
                if (gnt != 4'b0000) begin
                    if (g_seen && g_run > 0) chk("gnt_gap", 32'(g_run), 32'(G_GAP1));
                    g_seen = 1'b1; g_run = 0;
                end else g_run++;
            end
            if (!gap_en_z) begin
                oe_seen_z = 1'b0; g_seen_z = 1'b0; oe_run_z = 0; g_run_z = 0;
            end else begin
                if (pin_oe_z != 8'h00) begin
                    if (oe_seen_z && oe_run_z > 0) chk("oe_gap_t0", 32'(oe_run_z), 32'(OE_GAP0));
                    oe_seen_z = 1'b1; oe_run_z = 0;
                end else oe_run_z++;
                if (gnt_z != 4'b0000) begin
                    if (g_seen_z && g_run_z > 0) chk("gnt_gap_t0", 32'(g_run_z), 32'(G_GAP0));
                    g_seen_z = 1'b1; g_run_z = 0;
                end else g_run_z++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] exp_z [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        rst = 1'b1; req = 4'b0; last = 4'b0; req_z = 4'b0; last_z = 4'b0;
        wdata = {dat_tab[3], dat_tab[2], dat_tab[1], dat_tab[0]};
        woe   = {oe_tab[3], oe_tab[2], oe_tab[1], oe_tab[0]};
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_pin_oe", 32'(pin_oe), 32'h0);
        chk("rst_pin_out", 32'(pin_out), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        // Single request: gnt in cycle 1, pins from cycle 2, release at cycle 5.
        req = 4'b0001; exp_q.push_back(0);
        tick();
        chk("t1_gnt_c1", 32'(gnt), 32'h1);
        tick();
        chk("t1_pin_out_c2", 32'(pin_out), 32'hA5);
        chk("t1_pin_oe_c2", 32'(pin_oe), 32'hFF);
        tick(); tick(); tick();
        last = 4'b0001; req = 4'b0000;
        tick();
        last = 4'b0000;
        chk("t1_pin_oe_c6", 32'(pin_oe), 32'h0);
        chk("t1_gnt_c6", 32'(gnt), 32'h0);
        chk("t1_busy_c6", 32'(busy), 32'h1);
        tick();
        chk("t1_pin_oe_c7", 32'(pin_oe), 32'h0);
        tick();
        chk("t1_busy_c8", 32'(busy), 32'h0);

        // Round-robin fairness from ptr=0, each owner releases on its 3rd cycle.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; gap_en = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int i = 0; i < 4; i++) serve(3, 1'b0);
        serve(3, 1'b1);
        gap_en = 1'b0;
        tick();

        // Timeout: requester 2 never raises last; ptr is 1 so 2 wins.
        req = 4'b0100; exp_q.push_back(2);
        tick();
        n = (gnt == 4'b0100) ? 1 : 0;
        while (n > 0 && n < 40) begin
            tick();
            if (gnt == 4'b0100) n++;
            else break;
        end
        chk("to_hold_len", 32'(n), 32'd16);
        chk("to_pulse", 32'(timeout), 32'h1);
        // Pointer moved past 2 to 3: search 3,0,1 picks 1.
        req = 4'b0110; exp_q.push_back(1);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);
        serve(2, 1'b1);
        tick();

        // Coincident release: last on the 16th cycle (hold count 15), no timeout.
        req = 4'b1000; exp_q.push_back(3);
        serve(16, 1'b1);
        chk("co_gnt_rel", 32'(gnt), 32'h0);
        chk("co_timeout", 32'(timeout), 32'h0);
        tick();
        chk("co_timeout_n1", 32'(timeout), 32'h0);
        tick();

        // Reset mid-grant while owner 2 drives the pins.
        req = 4'b0100; exp_q.push_back(2);
        wait_gnt();
        tick(); tick();
        chk("mr_owner", 32'(owner), 32'h2);
        chk("mr_pin_oe", 32'(pin_oe), 32'hFF);
        rst = 1'b1; req = 4'b0000;
        #2;
        chk("mr_async_oe", 32'(pin_oe), 32'h0);
        chk("mr_async_gnt", 32'(gnt), 32'h0);
        chk("mr_async_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        req = 4'b0001; exp_q.push_back(0);
        tick();
        chk("mr_regrant", 32'(gnt), 32'h1);
        tick(); tick();
        req = 4'b0000;
        tick(); tick(); tick();

        // TURN_CYC=0 build: back-to-back 0011, each owner holds two cycles.
        req_z = 4'b0011; gap_en_z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (gnt_z == 4'b0000 && n < 20) begin tick(); n++; end
            chk("t0_owner", 32'(owner_z), 32'(exp_z[i]));
            chk("t0_gnt", 32'(gnt_z), 32'(1) << exp_z[i]);
            tick();
            last_z = gnt_z;
            if (i == 3) req_z = 4'b0000;
            tick();
            last_z = 4'b0000;
        end
        gap_en_z = 1'b0;
        tick(); tick(); tick();

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
